// File: rtl/svc_fb_pix_stream_if.sv
// Bundles the pixel stream and the AXI read channels (AR/R) of the frame-buffer streamer.
// The master modport is the streamer's view; the slave modport is the memory/display side.
interface svc_fb_pix_stream_if #(
    parameter int COLOR_WIDTH    = 4,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4
);
    // pixel stream
    logic                      m_pix_valid;
    logic                      m_pix_ready;
    logic [COLOR_WIDTH-1:0]    m_pix_red;
    logic [COLOR_WIDTH-1:0]    m_pix_grn;
    logic [COLOR_WIDTH-1:0]    m_pix_blu;
    logic                      m_pix_last;
    logic                      m_pix_eof;

    // AXI read address channel
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;
    logic [AXI_ID_WIDTH-1:0]   m_axi_arid;
    logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]                m_axi_arlen;
    logic [2:0]                m_axi_arsize;
    logic [1:0]                m_axi_arburst;

    // AXI read data channel
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;
    logic [AXI_ID_WIDTH-1:0]   m_axi_rid;
    logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rlast;

    modport master (
        output m_pix_valid, m_pix_red, m_pix_grn, m_pix_blu, m_pix_last, m_pix_eof,
        input  m_pix_ready,
        output m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        output m_axi_rready
    );

    modport slave (
        input  m_pix_valid, m_pix_red, m_pix_grn, m_pix_blu, m_pix_last, m_pix_eof,
        output m_pix_ready,
        input  m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        input  m_axi_rready
    );
endinterface

// File: rtl/svc_fb_pix_stream.sv
// Streams a frame buffer from an AXI read port as pixels with end-of-line/end-of-frame flags.
// AR side walks the frame in bursts (partial last burst allowed); R side is a zero-latency pass-through.
module svc_fb_pix_stream #(
    parameter int H_WIDTH         = 12,
    parameter int V_WIDTH         = 12,
    parameter int COLOR_WIDTH     = 4,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int BURST_LEN       = 128,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] fb_base,
    input  logic [H_WIDTH-1:0]        h_visible,
    input  logic [V_WIDTH-1:0]        v_visible,
    output logic                      rd_err,
    svc_fb_pix_stream_if.master       bus
);

    localparam int TOT_W      = H_WIDTH + V_WIDTH;
    localparam int CALC_W     = TOT_W + 9;
    localparam int WORD_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
    localparam int OFF_W      = TOT_W + WORD_SHIFT;
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW         = COLOR_WIDTH;

    // AR-side state and frame shadow
    logic                      arvalid_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]                arlen_q;
    logic [TOT_W-1:0]          word_idx;
    logic [AXI_ADDR_WIDTH-1:0] ar_base;
    logic [H_WIDTH-1:0]        ar_h;
    logic [V_WIDTH-1:0]        ar_v;
    logic [TOT_W-1:0]          ar_total;
    logic [OUT_W-1:0]          outstanding;

    // R-side state
    logic [H_WIDTH-1:0]        h_cnt;
    logic [V_WIDTH-1:0]        v_cnt;
    logic [H_WIDTH-1:0]        r_h;
    logic [V_WIDTH-1:0]        r_v;

    // combinational helpers
    logic [TOT_W-1:0]          total_in;
    logic                      frame_start;
    logic [TOT_W-1:0]          eff_total;
    logic [AXI_ADDR_WIDTH-1:0] eff_base;
    logic [CALC_W-1:0]         remain;
    logic [CALC_W-1:0]         beats;
    logic [CALC_W-1:0]         idx_sum;
    logic [TOT_W-1:0]          word_next;
    logic [OFF_W-1:0]          byte_off;
    logic [AXI_ADDR_WIDTH-1:0] araddr_next;
    logic [OUT_W-1:0]          out_next;
    logic                      ar_hs;
    logic                      pix_hs;
    logic                      r_last_hs;
    logic                      ar_load;
    logic                      pix_origin;
    logic [H_WIDTH-1:0]        cur_h;
    logic [V_WIDTH-1:0]        cur_v;
    logic                      line_end;
    logic                      frame_end;
    logic                      unused_r_bits;

    assign total_in    = TOT_W'(h_visible) * TOT_W'(v_visible);
    assign frame_start = (word_idx == '0);
    assign ar_hs       = arvalid_q && bus.m_axi_arready;
    assign pix_hs      = bus.m_axi_rvalid && bus.m_pix_ready;
    assign r_last_hs   = pix_hs && bus.m_axi_rlast;

    // At a frame boundary the live inputs are used so a new geometry takes effect immediately.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        eff_total   = ar_total;
        eff_base    = ar_base;
        if (frame_start) begin
            eff_total = total_in;
            eff_base  = fb_base;
        end
        remain      = CALC_W'(eff_total) - CALC_W'(word_idx);
        beats       = (remain < CALC_W'(BURST_LEN)) ? remain : CALC_W'(BURST_LEN);
        idx_sum     = CALC_W'(word_idx) + beats;
        word_next   = (idx_sum == CALC_W'(eff_total)) ? '0 : TOT_W'(idx_sum);
        byte_off    = OFF_W'(word_idx) << WORD_SHIFT;
        araddr_next = eff_base + AXI_ADDR_WIDTH'(byte_off);
    end

    always_comb begin
        out_next = outstanding;
        if (ar_hs && !r_last_hs)
            out_next = outstanding + OUT_W'(1);
        else if (!ar_hs && r_last_hs)
            out_next = outstanding - OUT_W'(1);
        ar_load = (!arvalid_q || bus.m_axi_arready)
                  && (out_next < OUT_W'(MAX_OUTSTANDING))
                  && (eff_total != '0);
    end

    // First pixel of a frame reads geometry from the AR shadow before the R shadow is refreshed.
    assign pix_origin = (h_cnt == '0) && (v_cnt == '0);
    assign cur_h      = pix_origin ? ar_h : r_h;
    assign cur_v      = pix_origin ? ar_v : r_v;
    assign line_end   = (h_cnt == cur_h - H_WIDTH'(1));
    assign frame_end  = line_end && (v_cnt == cur_v - V_WIDTH'(1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            word_idx    <= '0;
            ar_base     <= '0;
            ar_h        <= '0;
            ar_v        <= '0;
            ar_total    <= '0;
            outstanding <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            r_h         <= '0;
            r_v         <= '0;
            rd_err      <= 1'b0;
        end else begin
            outstanding <= out_next;

            if (ar_load) begin
                arvalid_q <= 1'b1;
                araddr_q  <= araddr_next;
                arlen_q   <= 8'(beats - CALC_W'(1));
                word_idx  <= word_next;
                if (frame_start) begin
                    ar_base  <= fb_base;
                    ar_h     <= h_visible;
                    ar_v     <= v_visible;
                    ar_total <= total_in;
                end
            end else if (bus.m_axi_arready) begin
                arvalid_q <= 1'b0;
            end

            if (pix_hs) begin
                if (pix_origin) begin
                    r_h <= ar_h;
                    r_v <= ar_v;
                end
                if (line_end) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == cur_v - V_WIDTH'(1)) ? '0 : v_cnt + V_WIDTH'(1);
                end else begin
                    h_cnt <= h_cnt + H_WIDTH'(1);
                end
                if (bus.m_axi_rresp != 2'b00)
                    rd_err <= 1'b1;
            end
        end
    end

    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arid    = '0;
    assign bus.m_axi_arsize  = 3'(WORD_SHIFT);
    assign bus.m_axi_arburst = 2'b01;

    assign bus.m_pix_valid   = bus.m_axi_rvalid;
    assign bus.m_axi_rready  = bus.m_pix_ready;
    assign bus.m_pix_red     = bus.m_axi_rdata[3*CW-1:2*CW];
    assign bus.m_pix_grn     = bus.m_axi_rdata[2*CW-1:CW];
    assign bus.m_pix_blu     = bus.m_axi_rdata[CW-1:0];
    assign bus.m_pix_last    = line_end;
    assign bus.m_pix_eof     = frame_end;

    // rid and the spare upper data bits carry nothing for this block.
    assign unused_r_bits = ^{bus.m_axi_rid, bus.m_axi_rdata};

endmodule

// File: tb/tb_svc_fb_pix_stream.sv
// Bench for svc_fb_pix_stream: an AXI memory slave plus a frame-order reference model
// check bursts, pixel order, line/frame flags and the sticky error flag under random backpressure.
module tb_svc_fb_pix_stream;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int IW  = 4;
    localparam int CW  = 4;
    localparam int BL  = 128;
    localparam int MAXO = 2;

    typedef struct {
        int addr;
        int len;
    } ar_rec_t;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] fb_base;
    logic [11:0]   h_vis;
    logic [11:0]   v_vis;
    logic          rd_err;

    svc_fb_pix_stream_if #(.COLOR_WIDTH(CW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                           .AXI_ID_WIDTH(IW)) bus ();

    svc_fb_pix_stream #(
        .H_WIDTH(12), .V_WIDTH(12), .COLOR_WIDTH(CW), .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .BURST_LEN(BL), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fb_base   (fb_base),
        .h_visible (h_vis),
        .v_visible (v_vis),
        .rd_err    (rd_err),
        .bus       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // memory image: content of pixel word w
    function automatic int img(input int w);
        return ((w * 37 + 5) ^ (w >> 3)) & 'hfff;
    endfunction

    // stimulus knobs
    bit arready_knob;
    int r_allow;
    int ready_pct;
    int err_beat;

    // slave and reference-model state
    ar_rec_t arq[$];
    ar_rec_t ar_log[$];
    int beat_in_burst, beat_global;
    int exp_word, exp_pix, out_cnt;
    int ar_count, rlast_count, pix_count, last_count, eof_count;
    bit exp_err;

    // driver / monitor: sample at negedge, drive just after posedge
    initial begin
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rid     = '0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rlast   = 1'b0;
        bus.m_pix_ready   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arq.delete();
                ar_log.delete();
                beat_in_burst = 0; beat_global = 0;
                exp_word = 0; exp_pix = 0; out_cnt = 0;
                ar_count = 0; rlast_count = 0; pix_count = 0;
                last_count = 0; eof_count = 0;
                exp_err = 1'b0;
            end else begin
                int total;
                total = int'(h_vis) * int'(v_vis);
                check("passthru", {bus.m_pix_valid, bus.m_axi_rready},
                      {bus.m_axi_rvalid, bus.m_pix_ready});
                check("rd_err", rd_err, exp_err);

                if (bus.m_axi_rvalid && bus.m_pix_ready) begin
                    int w;
                    w = int'(fb_base) / 2 + exp_pix;
                    check("pixel",
                          {bus.m_pix_red, bus.m_pix_grn, bus.m_pix_blu, bus.m_pix_last, bus.m_pix_eof},
                          {img(w) & 'hfff, 1'b0, 1'b0} |
                          64'((((exp_pix % int'(h_vis)) == int'(h_vis) - 1) ? 2 : 0) +
                              ((exp_pix == total - 1) ? 1 : 0)));
                    if (bus.m_pix_last) last_count++;
                    if (bus.m_pix_eof)  eof_count++;
                    if (bus.m_axi_rresp != 2'b00) exp_err = 1'b1;
                    exp_pix = (exp_pix + 1) % total;
                    pix_count++;
                    beat_global++;
                    if (bus.m_axi_rlast) begin
                        void'(arq.pop_front());
                        beat_in_burst = 0;
                        out_cnt--;
                        rlast_count++;
                        r_allow--;
                    end else begin
                        beat_in_burst++;
                    end
                end

                if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                    int blen;
                    ar_rec_t rec;
                    blen = (total - exp_word < BL) ? total - exp_word : BL;
                    check("araddr", bus.m_axi_araddr, (int'(fb_base) + 2 * exp_word) & 'hffff);
                    check("arlen", bus.m_axi_arlen, blen - 1);
                    check("ar_fixed", {bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst},
                          {4'd0, 3'd1, 2'b01});
                    check("out_limit", (out_cnt + 1 <= MAXO), 1'b1);
                    exp_word = (exp_word + blen == total) ? 0 : exp_word + blen;
                    rec.addr = int'(bus.m_axi_araddr);
                    rec.len  = int'(bus.m_axi_arlen);
                    arq.push_back(rec);
                    ar_log.push_back(rec);
                    out_cnt++;
                    ar_count++;
                end
            end

            @(posedge clk);
            #1;
            bus.m_axi_arready = arready_knob;
            bus.m_pix_ready   = ($urandom_range(99) < ready_pct);
            bus.m_axi_rvalid  = rst_n && (arq.size() > 0) && (r_allow > 0);
            if (arq.size() > 0) begin
                bus.m_axi_rdata = DW'(img((arq[0].addr + 2 * beat_in_burst) / 2));
                bus.m_axi_rlast = (beat_in_burst == arq[0].len);
                bus.m_axi_rresp = (beat_global == err_beat) ? 2'b10 : 2'b00;
            end else begin
                bus.m_axi_rlast = 1'b0;
                bus.m_axi_rresp = 2'b00;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int base, input int h, input int v,
                            input bit ar_rdy, input bit r_hold);
        rst_n        = 1'b0;
        fb_base      = AW'(base);
        h_vis        = 12'(h);
        v_vis        = 12'(v);
        arready_knob = ar_rdy;
        r_allow      = r_hold ? 0 : 32'h3fff_ffff;
        ready_pct    = 100;
        err_beat     = -1;
        cyc(3);
        check("rst_arvalid", bus.m_axi_arvalid, 1'b0);
        check("rst_rd_err", rd_err, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic wait_pix(input int n, input int budget);
        int c = 0;
        while (pix_count < n && c < budget) begin
            cyc(1);
            c++;
        end
        check("wait_pix", pix_count >= n, 1'b1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;

        // zero-sized frame: no reads at all
        do_reset('h1000, 0, 5, 1'b1, 1'b0);
        cyc(20);
        check("zero_ar_count", ar_count, 0);
        check("zero_arvalid", bus.m_axi_arvalid, 1'b0);

        // 256x2 frame, full bursts, two frames
        do_reset('h1000, 256, 2, 1'b1, 1'b0);
        wait_pix(1024, 3000);
        check("t1_ar0", {ar_log[0].addr, ar_log[0].len}, {32'h1000, 32'd127});
        check("t1_ar1", {ar_log[1].addr, ar_log[1].len}, {32'h1100, 32'd127});
        check("t1_ar2", {ar_log[2].addr, ar_log[2].len}, {32'h1200, 32'd127});
        check("t1_ar3", {ar_log[3].addr, ar_log[3].len}, {32'h1300, 32'd127});
        check("t1_ar4", {ar_log[4].addr, ar_log[4].len}, {32'h1000, 32'd127});
        check("t1_lasts", last_count, 4);
        check("t1_eofs", eof_count, 2);

        // 200x1 frame: partial final burst
        do_reset('h2000, 200, 1, 1'b1, 1'b0);
        wait_pix(400, 1500);
        check("t2_ar0", {ar_log[0].addr, ar_log[0].len}, {32'h2000, 32'd127});
        check("t2_ar1", {ar_log[1].addr, ar_log[1].len}, {32'h2100, 32'd71});
        check("t2_ar2", {ar_log[2].addr, ar_log[2].len}, {32'h2000, 32'd127});
        check("t2_eofs", eof_count, 2);

        // outstanding limit while R data is withheld
        do_reset('h3000, 256, 2, 1'b1, 1'b1);
        cyc(30);
        check("t3_ar_hold", ar_count, 2);
        check("t3_arvalid_hold", bus.m_axi_arvalid, 1'b0);
        r_allow = 1;
        begin
            int c = 0;
            while (rlast_count < 1 && c < 500) begin
                cyc(1);
                c++;
            end
        end
        check("t3_rlast", rlast_count, 1);
        cyc(10);
        check("t3_ar_after", ar_count, 3);
        check("t3_arvalid_after", bus.m_axi_arvalid, 1'b0);
        r_allow = 32'h3fff_ffff;
        wait_pix(600, 2000);

        // AR held while arready is low
        do_reset('h4000, 256, 2, 1'b0, 1'b0);
        begin
            int c = 0;
            logic [AW-1:0] a0;
            logic [7:0]    l0;
            while (!bus.m_axi_arvalid && c < 10) begin
                cyc(1);
                c++;
            end
            check("t4_arvalid", bus.m_axi_arvalid, 1'b1);
            a0 = bus.m_axi_araddr;
            l0 = bus.m_axi_arlen;
            for (int i = 0; i < 5; i++) begin
                cyc(1);
                check("t4_stable", {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen},
                      {1'b1, a0, l0});
            end
            check("t4_no_hs", ar_count, 0);
        end
        arready_knob = 1'b1;
        wait_pix(512, 2000);
        check("t4_ar0", {ar_log[0].addr, ar_log[0].len}, {32'h4000, 32'd127});

        // random pixel backpressure over three 16x8 frames
        do_reset('h0400, 16, 8, 1'b1, 1'b0);
        ready_pct = 60;
        wait_pix(384, 5000);
        check("t5_lasts", last_count, 24);
        check("t5_eofs", eof_count, 3);

        // one errored beat: sticky flag, stream continues, reset clears it
        do_reset('h1000, 256, 2, 1'b1, 1'b0);
        err_beat = 50;
        ready_pct = 80;
        wait_pix(300, 2000);
        check("t6_rd_err", rd_err, 1'b1);
        cyc(50);
        check("t6_rd_err_sticky", rd_err, 1'b1);
        check("t6_stream_on", pix_count > 300, 1'b1);
        do_reset('h1000, 256, 2, 1'b1, 1'b0);
        cyc(5);
        check("t6_rd_err_cleared", rd_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
